pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 64 ++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC register with boot/run/halt FSM, redirect/stall priority and saturating perf counters
module pc_fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h00400030,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic [WIDTH-1:0]     PC,
  input  logic                 redirect,
  input  logic [WIDTH-1:0]     redirect_pc,
  input  logic                 halt,
  output logic [WIDTH-1:0]     PCF,
  output logic                 pc_valid,
  output logic                 misaligned,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] redirect_count
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
  state_t st;
  function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction
  assign state      = st;
  assign pc_valid   = st == RUN;
  assign misaligned = |PCF[1:0];
  // FSM, PC register and counters; redirect wins over stall, stall over advance, halt only steers the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF            <= RESET_PC;
      st             <= BOOT;
      fetch_count    <= '0;
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      case (st)
        BOOT: st <= halt ? HALTED : RUN;
        RUN: begin
          if (redirect) begin
            PCF            <= redirect_pc;
            redirect_count <= sat(redirect_count);
          end else if (StallF) begin
            stall_count <= sat(stall_count);
          end else begin
            PCF         <= PC;
            fetch_count <= sat(fetch_count);
          end
          st <= halt ? HALTED : RUN;
        end
        HALTED: begin
          if (redirect) begin
            PCF            <= redirect_pc;
            redirect_count <= sat(redirect_count);
          end
          st <= halt ? HALTED : RUN;
        end
        default: st <= BOOT;
      endcase
    end
  end
endmodule
